// File: rtl/data_bus_demux.sv
// RAM read-return demux: steers data_bus words to the fetch or load holding register.
// Optional LOAD_EXT_EN adds byte/half selection and sign/zero extension on the load path.
module data_bus_demux #(
   parameter int DATA_WIDTH  = 32,
   parameter int RAM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  select,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] data_bus,
`ifdef LOAD_EXT_EN
   input  logic [1:0]            load_size,
   input  logic                  load_signed,
   input  logic [1:0]            addr_lsb,
`endif
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_valid,
   input  logic                  load_ready,
   output logic                  busy,
   output logic                  ovf_err
);

   typedef struct packed {
      logic       valid;
      logic       dest;   // 0 = fetch, 1 = load
`ifdef LOAD_EXT_EN
      logic [1:0] size;
      logic       sgn;
      logic [1:0] lsb;
`endif
   } tag_t;

   tag_t                  tag_q [RAM_LATENCY];
   tag_t                  tag_new;
   tag_t                  tag_last;
   logic [DATA_WIDTH-1:0] load_word;
   logic                  ret_instr;
   logic                  ret_load;

`ifdef LOAD_EXT_EN
   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] w,
                                                    input tag_t t);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*t.lsb +: 8];
      h = t.lsb[1] ? w[31:16] : w[15:0];
      case (t.size)
         2'd0:    extend = t.sgn ? {{(DATA_WIDTH-8){b[7]}}, b} : {{(DATA_WIDTH-8){1'b0}}, b};
         2'd1:    extend = t.sgn ? {{(DATA_WIDTH-16){h[15]}}, h} : {{(DATA_WIDTH-16){1'b0}}, h};
         default: extend = w;
      endcase
   endfunction
`endif

   always_comb begin
      tag_new       = '0;
      tag_new.valid = req_valid & ~req_write;
      tag_new.dest  = select;
`ifdef LOAD_EXT_EN
      // Extension controls only matter for load tags; fetch tags carry zeros.
      if (select) begin
         tag_new.size = load_size;
         tag_new.sgn  = load_signed;
         tag_new.lsb  = addr_lsb;
      end
`endif
   end

   assign tag_last  = tag_q[RAM_LATENCY-1];
   assign ret_instr = tag_last.valid & ~tag_last.dest;
   assign ret_load  = tag_last.valid & tag_last.dest;

`ifdef LOAD_EXT_EN
   assign load_word = extend(data_bus, tag_last);
`else
   assign load_word = data_bus;
`endif

   always_comb begin
      busy = instr_valid | load_valid;
      for (int i = 0; i < RAM_LATENCY; i++) busy = busy | tag_q[i].valid;
   end

   // NOTE: non-blocking assignments here so every stage and register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RAM_LATENCY; i++) tag_q[i] <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
         load_data   <= '0;
         load_valid  <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         tag_q[0] <= tag_new;
         for (int i = 1; i < RAM_LATENCY; i++) tag_q[i] <= tag_q[i-1];

         // A return into a full, stalled register is dropped and flagged.
         if (ret_instr) begin
            if (instr_valid && !instr_ready) begin
               ovf_err <= 1'b1;
            end else begin
               instr_out   <= data_bus;
               instr_valid <= 1'b1;
            end
         end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
         end

         if (ret_load) begin
            if (load_valid && !load_ready) begin
               ovf_err <= 1'b1;
            end else begin
               load_data  <= load_word;
               load_valid <= 1'b1;
            end
         end else if (load_valid && load_ready) begin
            load_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_bus_demux.sv
// Scoreboard bench for data_bus_demux: a RAM model schedules return data, expected words are
// queued per destination at request time and matched when the DUT hands them over.
module tb_data_bus_demux;
   localparam int DW = 32;
   localparam int L  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          select;
   logic          req_valid;
   logic          req_write;
   logic [DW-1:0] data_bus;
   logic [DW-1:0] instr_out;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] load_data;
   logic          load_valid;
   logic          load_ready;
   logic          busy;
   logic          ovf_err;
`ifdef LOAD_EXT_EN
   logic [1:0]    load_size;
   logic          load_signed;
   logic [1:0]    addr_lsb;
`endif

   data_bus_demux #(.DATA_WIDTH(DW), .RAM_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .select(select), .req_valid(req_valid),
      .req_write(req_write), .data_bus(data_bus),
`ifdef LOAD_EXT_EN
      .load_size(load_size), .load_signed(load_signed), .addr_lsb(addr_lsb),
`endif
      .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
      .busy(busy), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;   // expected hand-over cycle, -1 = not timed
   } exp_t;

   exp_t          instr_q [$];
   exp_t          load_q  [$];
   exp_t          mon_e;
   logic [DW-1:0] ram_data [int];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] load_model(input logic [DW-1:0] d);
`ifdef LOAD_EXT_EN
      logic [7:0]  b;
      logic [15:0] h;
      case (addr_lsb)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = addr_lsb[1] ? d[31:16] : d[15:0];
      if (load_size == 2'd0) return load_signed ? {{24{b[7]}}, b} : {24'h0, b};
      if (load_size == 2'd1) return load_signed ? {{16{h[15]}}, h} : {16'h0, h};
      return d;
`else
      return d;
`endif
   endfunction

   // Drive one cycle of stimulus; reads schedule RAM data L cycles later and queue expectations.
   task automatic step(input bit rv, input bit sel, input bit rw, input logic [DW-1:0] d);
      exp_t e;
      req_valid = rv;
      select    = sel;
      req_write = rw;
      if (rv && !rw && !reset) begin
         ram_data[cyc+L] = d;
         e.cyc = cyc + L + 1;
         if (sel) begin
            e.data = load_model(d);
            load_q.push_back(e);
         end else begin
            e.data = d;
            instr_q.push_back(e);
         end
      end
      data_bus = ram_data.exists(cyc) ? ram_data[cyc] : DW'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
   endtask

   // Outputs are sampled mid-cycle; a word is consumed when valid && ready.
   always @(negedge clk) begin
      if (!reset) begin
         if (instr_valid && instr_ready) begin
            if (instr_q.size() == 0) check("instr_unexpected", 1, 0);
            else begin
               mon_e = instr_q.pop_front();
               check("instr_data", instr_out, mon_e.data);
               if (mon_e.cyc >= 0) check("instr_latency", cyc, mon_e.cyc);
            end
         end
         if (load_valid && load_ready) begin
            if (load_q.size() == 0) check("load_unexpected", 1, 0);
            else begin
               mon_e = load_q.pop_front();
               check("load_data", load_data, mon_e.data);
               if (mon_e.cyc >= 0) check("load_latency", cyc, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      exp_t e;
      reset       = 1'b1;
      instr_ready = 1'b1;
      load_ready  = 1'b1;
`ifdef LOAD_EXT_EN
      load_size   = 2'd2;
      load_signed = 1'b0;
      addr_lsb    = 2'd0;
`endif
      step(1'b1, 1'b0, 1'b0, 32'h1111_1111);
      step(1'b1, 1'b1, 1'b0, 32'h2222_2222);
      reset = 1'b0;

      check("rst_instr_valid", instr_valid, 0);
      check("rst_load_valid", load_valid, 0);
      check("rst_instr_out", instr_out, 0);
      check("rst_load_data", load_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf_err, 0);
      idle(3);

      // Single fetch, single load, then alternating destinations.
      step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
      check("busy_inflight", busy, 1);
      idle(4);
      step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
      idle(4);
      step(1'b1, 1'b0, 1'b0, 32'hA1A1_0001);
      step(1'b1, 1'b1, 1'b0, 32'hB2B2_0002);
      step(1'b1, 1'b0, 1'b0, 32'hC3C3_0003);
      idle(5);

      // Store issues no tag.
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      check("store_busy_1", busy, 0);
      idle(1);
      check("store_busy_2", busy, 0);
      idle(3);

      // Sustained random reads, one per cycle.
      for (int i = 0; i < 16; i++) begin
`ifdef LOAD_EXT_EN
         load_size   = 2'($urandom);
         load_signed = 1'($urandom);
         addr_lsb    = 2'($urandom);
`endif
         step(1'b1, 1'($urandom), 1'b0, DW'($urandom));
      end
      idle(5);

`ifdef LOAD_EXT_EN
      load_size = 2'd0; load_signed = 1'b1; addr_lsb = 2'd1;
      step(1'b1, 1'b1, 1'b0, 32'h0000_80FF);
      load_size = 2'd1; load_signed = 1'b0; addr_lsb = 2'd0;
      step(1'b1, 1'b1, 1'b0, 32'h0000_80FF);
      step(1'b1, 1'b0, 1'b0, 32'h0000_80FF);
      idle(5);
`endif

      // Overflow: fetch register stalled, second word must be dropped.
      instr_ready = 1'b0;
      step(1'b1, 1'b0, 1'b0, 32'h0000_0001);
      step(1'b1, 1'b0, 1'b0, 32'h0000_0002);
      idle(4);
      check("ovf_instr_valid", instr_valid, 1);
      check("ovf_instr_out", instr_out, 32'h0000_0001);
      check("ovf_flag", ovf_err, 1);
      e = instr_q.pop_front();
      void'(instr_q.pop_back());
      e.cyc = -1;
      instr_q.push_front(e);
      instr_ready = 1'b1;
      idle(2);
      check("ovf_drained", instr_valid, 0);
      check("ovf_sticky", ovf_err, 1);

      // Reset mid-flight: fetch then reset; its data still appears on data_bus later.
      step(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
      reset = 1'b1;
      instr_q.delete();
      load_q.delete();
      step(1'b1, 1'b0, 1'b0, 32'h0000_0055);
      reset = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ovf", ovf_err, 0);
      idle(1);
      check("rst_mid_busy_2", busy, 0);
      check("rst_mid_instr_valid", instr_valid, 0);
      idle(4);

      check("instr_q_empty", instr_q.size(), 0);
      check("load_q_empty", load_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
